// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter. Each input may take up to max(weight,1)
// consecutive grants before priority rotates to the next requester.
module wrr_arb_tree #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter type         DataType    = logic [DataWidth-1:0],
  parameter int unsigned WeightWidth = 4,
  parameter bit          AxiVldRdy   = 1'b0,
  parameter bit          LockIn      = 1'b1,
  localparam int unsigned IdxWidth   = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]             req_i,
  output logic [NumIn-1:0]             gnt_o,
  input  DataType [NumIn-1:0]          data_i,
  output logic                         req_o,
  input  logic                         gnt_i,
  output DataType                      data_o,
  output logic [IdxWidth-1:0]          idx_o,
  output logic [WeightWidth-1:0]       credit_o
);

  localparam logic [IdxWidth-1:0] OwnerRst = IdxWidth'(NumIn - 1);

  logic [IdxWidth-1:0]    owner_q, sel_q;
  logic [WeightWidth-1:0] credit_q;
  logic                   lock_q;

  logic [NumIn-1:0]       req_eff;
  logic [IdxWidth-1:0]    search_idx, cand, win;
  logic [WeightWidth-1:0] weight_arr [NumIn];
  logic [WeightWidth-1:0] win_weight, burst_credit;
  logic                   xfer;

  always_comb begin
    for (int i = 0; i < int'(NumIn); i++) begin
      weight_arr[i] = weight_i[i*WeightWidth +: WeightWidth];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps these blocks from inferring latches.
  always_comb begin
    req_eff = req_i;
    if (LockIn && lock_q) begin
      req_eff        = '0;
      req_eff[sel_q] = req_i[sel_q];
    end
  end

  // Walk the ring backwards so the last hit kept is the first requester after owner_q.
  always_comb begin
    search_idx = '0;
    cand       = '0;
    for (int i = int'(NumIn); i >= 1; i--) begin
      cand = IdxWidth'((int'(owner_q) + i) % int'(NumIn));
      if (req_eff[cand]) search_idx = cand;
    end
  end

  always_comb begin
    if (LockIn && lock_q)                          win = sel_q;
    else if (credit_q != '0 && req_eff[owner_q])   win = owner_q;
    else                                           win = search_idx;
  end

  always_comb begin
    gnt_o      = '0;
    gnt_o[win] = gnt_i & (AxiVldRdy | req_eff[win]);
  end

  assign req_o    = |req_eff;
  assign idx_o    = req_o ? win : '0;
  assign data_o   = req_o ? data_i[win] : '0;
  assign credit_o = credit_q;
  assign xfer     = req_o & gnt_i;

  // A weight of zero still earns one grant, leaving no credit afterwards.
  assign win_weight   = weight_arr[win];
  assign burst_credit = (win_weight == '0) ? '0 : win_weight - WeightWidth'(1);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      owner_q  <= OwnerRst;
      credit_q <= '0;
      lock_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      if (xfer) begin
        if (win == owner_q && credit_q != '0) begin
          credit_q <= credit_q - WeightWidth'(1);
        end else begin
          owner_q  <= win;
          credit_q <= burst_credit;
        end
      end
      lock_q <= LockIn && req_o && !gnt_i;
      sel_q  <= win;
    end
  end

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Bench for wrr_arb_tree: a rule-level reference model compared every cycle on three
// configurations (4 inputs with lock-in, 1 input valid/ready, 3 inputs without lock-in).
module tb_wrr_arb_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush;

  logic [15:0]      wt4;
  logic [3:0]       req4, gnt_o4, cr4;
  logic             gi4, rq_o4;
  logic [3:0][31:0] d4;
  logic [31:0]      do4;
  logic [1:0]       idx4;

  logic [3:0]       wt1, cr1;
  logic [0:0]       req1, gnt_o1, idx1;
  logic             gi1, rq_o1;
  logic [0:0][31:0] d1;
  logic [31:0]      do1;

  logic [11:0]      wt3;
  logic [2:0]       req3, gnt_o3;
  logic [3:0]       cr3;
  logic             gi3, rq_o3;
  logic [2:0][31:0] d3;
  logic [31:0]      do3;
  logic [1:0]       idx3;

  wrr_arb_tree dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .weight_i(wt4), .req_i(req4),
    .gnt_o(gnt_o4), .data_i(d4), .req_o(rq_o4), .gnt_i(gi4), .data_o(do4),
    .idx_o(idx4), .credit_o(cr4)
  );

  wrr_arb_tree #(.NumIn(1), .AxiVldRdy(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .weight_i(wt1), .req_i(req1),
    .gnt_o(gnt_o1), .data_i(d1), .req_o(rq_o1), .gnt_i(gi1), .data_o(do1),
    .idx_o(idx1), .credit_o(cr1)
  );

  wrr_arb_tree #(.NumIn(3), .LockIn(1'b0)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .weight_i(wt3), .req_i(req3),
    .gnt_o(gnt_o3), .data_i(d3), .req_o(rq_o3), .gnt_i(gi3), .data_o(do3),
    .idx_o(idx3), .credit_o(cr3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules stated over plain integers.
  typedef struct { int owner; int credit; bit lock; int sel; } mst_t;
  typedef struct { bit rq; int w; int idx; logic [3:0] gnt; } mout_t;

  function automatic mst_t m_rst(input int n);
    mst_t s;
    s.owner = n - 1; s.credit = 0; s.lock = 1'b0; s.sel = 0;
    return s;
  endfunction

  function automatic mout_t m_out(input int n, input bit lockin, input bit axi,
                                  input mst_t s, input logic [3:0] req, input logic g);
    mout_t      o;
    logic [3:0] eff;
    eff = req;
    if (lockin && s.lock) begin
      eff = '0;
      eff[s.sel] = req[s.sel];
    end
    o.w = 0;
    if (lockin && s.lock) o.w = s.sel;
    else if (s.credit != 0 && eff[s.owner]) o.w = s.owner;
    else begin
      for (int k = 1; k <= n; k++) begin
        if (eff[(s.owner + k) % n]) begin
          o.w = (s.owner + k) % n;
          break;
        end
      end
    end
    o.rq       = |eff;
    o.idx      = o.rq ? o.w : 0;
    o.gnt      = '0;
    o.gnt[o.w] = g & (axi | eff[o.w]);
    return o;
  endfunction

  function automatic mst_t m_next(input bit lockin, input mst_t s, input mout_t o,
                                  input logic g, input logic [15:0] wt);
    mst_t ns;
    int   wv;
    ns = s;
    if (o.rq && g) begin
      if (o.w == s.owner && s.credit != 0) ns.credit = s.credit - 1;
      else begin
        wv        = int'(wt[o.w*4 +: 4]);
        ns.owner  = o.w;
        ns.credit = (wv == 0) ? 0 : wv - 1;
      end
    end
    if (lockin) begin
      ns.lock = o.rq && !g;
      ns.sel  = o.w;
    end
    return ns;
  endfunction

  mst_t  ms4, ms1, ms3;
  mout_t o4, o1, o3;
  bit    armed = 1'b0;

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      ms4 = m_rst(4); ms1 = m_rst(1); ms3 = m_rst(3);
    end else begin
      ms4 = m_next(1'b1, ms4, m_out(4, 1'b1, 1'b0, ms4, req4, gi4), gi4, wt4);
      ms1 = m_next(1'b0, ms1, m_out(1, 1'b0, 1'b1, ms1, 4'(req1), gi1), gi1, 16'(wt1));
      ms3 = m_next(1'b0, ms3, m_out(3, 1'b0, 1'b0, ms3, 4'(req3), gi3), gi3, 16'(wt3));
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      o4 = m_out(4, 1'b1, 1'b0, ms4, req4, gi4);
      check("m4_req_o",  rq_o4,  o4.rq);
      check("m4_idx",    idx4,   o4.idx);
      check("m4_data",   do4,    o4.rq ? d4[o4.w] : 32'd0);
      check("m4_gnt",    gnt_o4, o4.gnt);
      check("m4_credit", cr4,    ms4.credit);
      check("a4_onehot", $onehot0(gnt_o4), 1);
      check("a4_gnt_implies_gnt_i", (|gnt_o4) && !gi4, 0);
      if (rq_o4 && gi4) check("a4_gnt_at_idx", gnt_o4[idx4], 1);
      if (|req4)        check("a4_req_implies_req_o", rq_o4, 1);
      if (ms4.lock)     check("a4_locked_req_held", req4[ms4.sel], 1);

      o1 = m_out(1, 1'b0, 1'b1, ms1, 4'(req1), gi1);
      check("m1_req_o",  rq_o1,  o1.rq);
      check("m1_idx",    idx1,   o1.idx);
      check("m1_data",   do1,    o1.rq ? d1[0] : 32'd0);
      check("m1_gnt",    gnt_o1, o1.gnt[0]);
      check("m1_credit", cr1,    ms1.credit);

      o3 = m_out(3, 1'b0, 1'b0, ms3, 4'(req3), gi3);
      check("m3_req_o",  rq_o3,  o3.rq);
      check("m3_idx",    idx3,   o3.idx);
      check("m3_data",   do3,    o3.rq ? d3[o3.w] : 32'd0);
      check("m3_gnt",    gnt_o3, o3.gnt[2:0]);
      check("m3_credit", cr3,    ms3.credit);
      check("a3_onehot", $onehot0(gnt_o3), 1);
      if (|req3) check("a3_req_implies_req_o", rq_o3, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  int exp_idx1 [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
  int exp_cr1  [10] = '{0, 2, 1, 0, 0, 1, 0, 0, 2, 1};
  int exp_idx4 [6]  = '{0, 0, 0, 1, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    wt4 = 16'h0213; req4 = '0; gi4 = 1'b0;
    wt1 = 4'd3;     req1 = '0; gi1 = 1'b0;
    wt3 = 12'h111;  req3 = '0; gi3 = 1'b0;
    for (int i = 0; i < 4; i++) d4[i] = 32'hDA7A_0000 + 32'(i);
    for (int i = 0; i < 3; i++) d3[i] = 32'h3333_0000 + 32'(i);
    d1[0] = 32'h1111_0001;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state, with downstream ready but nothing requesting.
    gi4 = 1'b1;
    mid();
    check("rst_req_o",  rq_o4,  0);
    check("rst_idx",    idx4,   0);
    check("rst_credit", cr4,    0);
    check("rst_gnt",    gnt_o4, 0);
    tick();

    // Weights {3,1,2,0}, everyone requesting.
    req4 = 4'hf;
    for (int k = 0; k < 10; k++) begin
      mid();
      check("t1_idx",    idx4, exp_idx1[k]);
      check("t1_credit", cr4,  exp_cr1[k]);
      tick();
    end

    // Owner 0 forfeits its remaining credit, then returns for a fresh burst.
    req4 = '0;
    do_flush();
    req4 = 4'hf;
    mid(); check("t2_first_idx", idx4, 0); tick();
    req4 = 4'b1110;
    mid(); check("t2_forfeit_idx", idx4, 1); check("t2_credit_before", cr4, 2); tick();
    req4 = 4'b0001;
    mid(); check("t2_no_carry_credit", cr4, 0); check("t2_back_idx", idx4, 0); tick();
    mid(); check("t2_fresh_credit", cr4, 2); tick();
    mid(); check("t2_burst_idx", idx4, 0); check("t2_burst_credit", cr4, 1); tick();
    mid(); check("t2_burst_last", cr4, 0); tick();

    // Lock-in holds input 2 while a lower index starts requesting.
    req4 = '0;
    do_flush();
    req4 = 4'b0100; gi4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("t3_idx", idx4, 2); check("t3_data", do4, d4[2]);
      check("t3_req_o", rq_o4, 1); check("t3_gnt_idle", gnt_o4, 0);
      tick();
    end
    req4 = 4'b0110;
    mid(); check("t3_locked_idx", idx4, 2); check("t3_locked_data", do4, d4[2]); tick();
    gi4 = 1'b1;
    mid(); check("t3_gnt", gnt_o4, 4'b0100); check("t3_gnt_idx", idx4, 2); tick();

    // Weight change mid-burst only takes effect on the next burst.
    req4 = '0;
    do_flush();
    req4 = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      mid();
      check("t4_idx", idx4, exp_idx4[k]);
      tick();
      if (k == 0) wt4 = 16'h0211;
    end

    // Reset, then flush, mid-burst (owner 2, credit 1).
    wt4 = 16'h0213;
    for (int v = 0; v < 2; v++) begin
      req4 = '0;
      do_flush();
      req4 = 4'hf;
      repeat (5) tick();
      mid(); check("t5_pre_credit", cr4, 1); check("t5_pre_idx", idx4, 2);
      if (v == 0) rst_n = 1'b0;
      else        flush = 1'b1;
      tick();
      rst_n = 1'b1; flush = 1'b0;
      mid(); check("t5_post_credit", cr4, 0); check("t5_post_idx", idx4, 0);
      tick();
    end
    req4 = '0; gi4 = 1'b0;

    // Single input: pass-through.
    req1 = 1'b1; gi1 = 1'b0;
    mid();
    check("t6a_req_o", rq_o1, 1); check("t6a_gnt_idle", gnt_o1, 0); check("t6a_idx", idx1, 0);
    gi1 = 1'b1;
    #1; check("t6a_gnt", gnt_o1, 1);
    tick();
    mid(); check("t6a_credit", cr1, 2);
    req1 = 1'b0;
    #1; check("t6a_req_o_low", rq_o1, 0);
    tick();
    gi1 = 1'b0;

    // Three inputs: wrap-around from owner 2, then no requests.
    req3 = 3'b100; gi3 = 1'b1;
    mid(); check("t6b_idx_owner", idx3, 2); tick();
    req3 = 3'b011;
    mid(); check("t6b_wrap_idx", idx3, 0); check("t6b_credit", cr3, 0); tick();
    req3 = 3'b000;
    mid();
    check("t6b_idle_req_o", rq_o3, 0); check("t6b_idle_idx", idx3, 0); check("t6b_idle_gnt", gnt_o3, 0);
    tick();
    gi3 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
